mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one sequential signed 32x32 Booth multiplier among NREQ requesters.
//  Round-robin arbitration, operand capture, and a single mul_start pulse per job.
//  Detects completion, returns the tagged 64-bit product, and guards against a hung multiplier with a timeout.
//  Sits between the ALU issue logic and the multiplier instance; multiplier reset is tied to ~rst_n at top level.
// PARAMETERS
//  NREQ        4    number of requesters (>=2)
//  W           32   operand width; product is 2*W
//  TIMEOUT_CYC 255  max ST_WAIT cycles before a job is aborted with error
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  req_valid   in   NREQ     per-requester job request
//  req_ready   out  NREQ     one-hot grant/accept
//  req_m       in   NREQ*W   multiplicands, requester i at [i*W +: W]
//  req_q       in   NREQ*W   multipliers, same packing
//  rsp_valid   out  1        response valid
//  rsp_ready   in   1        response accept
//  rsp_id      out  clog2(NREQ)  index of the requester owning the response
//  rsp_data    out  2*W      signed product (0 on error)
//  rsp_err     out  1        1 = job timed out
//  busy        out  1        high in any state other than ST_IDLE
//  mul_start   out  1        one-cycle start pulse to the multiplier
//  mul_m       out  W        latched multiplicand, stable from ST_START until return to ST_IDLE
//  mul_q       out  W        latched multiplier, same stability rule
//  mul_result  in   2*W      multiplier product
//  mul_done    in   1        multiplier done flag; level, sticky until next start
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs 0; state=ST_IDLE; timer=0; done_q=0.
//   - last_grant=NREQ-1, so requester 0 has top priority after reset.
//   - Reset mid-job abandons the job; no response is produced.
//  Handshakes
//   - A request transfers on req_valid[i] & req_ready[i]. Requesters hold valid and operands until ready.
//   - A response transfers on rsp_valid & rsp_ready.
//   - rsp_valid, rsp_id, rsp_data and rsp_err stay stable while rsp_ready=0.
//  FSM
//   - ST_IDLE: if any req_valid, the winner is the first valid index searching upward (modulo NREQ) from last_grant+1.
//     req_ready[winner]=1 combinationally, this state only. On accept: latch operands and id, go to ST_START.
//   - ST_START: mul_start=1 for exactly this cycle. Clear timer, go to ST_WAIT.
//   - ST_WAIT: completion is a rising edge of mul_done (mul_done & ~done_q, where done_q is registered every cycle).
//     A stale high mul_done from the previous job falls after the start pulse and is not a completion.
//     On completion: latch mul_result into rsp_data, rsp_err=0, go to ST_RESP.
//     Otherwise timer++; when timer==TIMEOUT_CYC: rsp_data=0, rsp_err=1, go to ST_RESP.
//   - ST_RESP: rsp_valid=1. On handshake: last_grant=rsp_id; go to ST_IDLE if err=0, else ST_DRAIN.
//   - ST_DRAIN: no grants. Wait for a mul_done rising edge (late completion, discarded), then go to ST_IDLE.
//  Sequencing rules
//   - Only one job is in flight; req_ready is all-zero outside ST_IDLE.
//   - Simultaneous requests are ordered purely by round-robin; a granted requester becomes lowest priority next.
//   - Back-to-back: ST_RESP handshake -> ST_IDLE, with the next grant possible the same cycle ST_IDLE is entered.
//   - Latency: accept at cycle t, mul_start at t+1, rsp_valid at multiplier completion +1.
//  Arithmetic
//   - Two's-complement signed product, full 2*W bits. No truncation or saturation.
// TESTING
//  1. r0: M=3, Q=-5. Expect rsp_id=0, rsp_data=-15 (0xFFFF_FFFF_FFFF_FFF1), rsp_err=0. Expect exactly one mul_start pulse.
//  2. All 4 valid after reset (r_i: M=i+1, Q=10). Expect grants in order 0,1,2,3 with products 10,20,30,40.
//     Then r0 and r2 re-request: expect 0 then 2.
//  3. rsp_ready held low for 20 cycles. Expect rsp_* stable, req_ready=0 throughout, no mul_start.
//  4. Stub multiplier never raises done, TIMEOUT_CYC=16. Expect rsp_err=1, rsp_data=0 after 16 ST_WAIT cycles.
//     No grant until the stub raises done; then the grant resumes.
//  5. rst_n pulsed low during ST_WAIT. Expect all outputs 0 immediately and no response.
//     Next simultaneous r1+r0 request: expect r0 granted first.
//  6. M=Q=-2^31. Expect rsp_data=0x4000_0000_0000_0000.
//     M=0x7FFFFFFF, Q=-1: expect 0xFFFF_FFFF_8000_0001.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that lets NREQ requesters share one sequential signed multiplier.
// One job in flight: grant, capture operands, pulse start, wait for done (with timeout), return tagged product.
module mult_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW         = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [NREQ*W-1:0]   req_m_i,
  input  logic [NREQ*W-1:0]   req_q_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IDW-1:0]      rsp_id_o,
  output logic [2*W-1:0]      rsp_data_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  output logic                mul_start_o,
  output logic [W-1:0]        mul_m_o,
  output logic [W-1:0]        mul_q_o,
  input  logic [2*W-1:0]      mul_result_i,
  input  logic                mul_done_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     q_q, q_d;
  logic [2*W-1:0]   data_q, data_d;
  logic             err_q, err_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             done_q;

  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [NREQ-1:0]  grant_s;
  logic [W-1:0]     m_sel_s;
  logic [W-1:0]     q_sel_s;
  logic             done_rise_s;

  assign done_rise_s = mul_done_i & ~done_q;

  // Round-robin pick: first valid index above last_q, then wrap to the lowest index.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    grant_s = '0;
    m_sel_s = '0;
    q_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid_i[i] && (i > int'(last_q))) begin
        found_s    = 1'b1;
        win_s      = IDW'(i);
        grant_s[i] = 1'b1;
        m_sel_s    = req_m_i[i*W +: W];
        q_sel_s    = req_q_i[i*W +: W];
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid_i[i] && (i <= int'(last_q))) begin
        found_s    = 1'b1;
        win_s      = IDW'(i);
        grant_s[i] = 1'b1;
        m_sel_s    = req_m_i[i*W +: W];
        q_sel_s    = req_q_i[i*W +: W];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grants only exist while idle; gating with rst_n keeps all outputs low during reset.
  always_comb begin
    if ((state_q == ST_IDLE) && rst_n) begin
      req_ready_o = grant_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Next-state and datapath update for the job sequencer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    m_d     = m_q;
    q_d     = q_q;
    data_d  = data_q;
    err_d   = err_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          id_d    = win_s;
          m_d     = m_sel_s;
          q_d     = q_sel_s;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A mul_done still high from the previous job drops after the start pulse, so only edges count.
        if (done_rise_s) begin
          data_d  = mul_result_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          last_d  = id_q;
          state_d = err_q ? ST_DRAIN : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_DRAIN: begin
        if (done_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      m_q     <= '0;
      q_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      m_q     <= m_d;
      q_q     <= q_d;
      data_q  <= data_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      done_q  <= mul_done_i;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign mul_start_o = (state_q == ST_START);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign mul_m_o     = m_q;
  assign mul_q_o     = q_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with a stub multiplier and a protocol-level reference model.
module tb_mult_share_arbiter;
  localparam int NREQ   = 4;
  localparam int W      = 32;
  localparam int TO_CYC = 16;
  localparam int IDW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_m, req_q;
  logic              rsp_valid, rsp_ready, rsp_err, busy, mul_start, mul_done;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data, mul_result;
  logic [W-1:0]      mul_m, mul_q;

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_m_i(req_m), .req_q_i(req_q),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .busy_o(busy), .mul_start_o(mul_start),
    .mul_m_o(mul_m), .mul_q_o(mul_q),
    .mul_result_i(mul_result), .mul_done_i(mul_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // requester drivers
  logic [NREQ-1:0] vld;
  logic [W-1:0]    m_a [NREQ];
  logic [W-1:0]    q_a [NREQ];
  logic [NREQ-1:0] acc_vec;
  int              rr_mode;
  bit              rand_mode, hang, rel_done;
  int              lat_lo, lat_hi;

  // reference model state
  int          phase;      // 0 idle, 1 start, 2 wait, 3 respond, 4 drain
  int          ref_last, w, cur_id, n_rsp, start_cnt;
  logic [W-1:0] cur_m, cur_q;
  logic [63:0] cur_data;
  logic        cur_err, prev_done;
  int          grant_log[$];
  int          rsp_log_id[$];
  logic [63:0] rsp_log_data[$];
  logic        rsp_log_err[$];

  function automatic logic [63:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // stub multiplier: done falls on start, rises after a random latency, or on demand when hung
  int cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      mul_done   <= 1'b0;
      mul_result <= '0;
      cnt        <= 0;
    end else if (mul_start) begin
      mul_done <= 1'b0;
      cnt      <= hang ? 0 : int'($urandom_range(lat_hi, lat_lo));
    end else if (rel_done && !mul_done) begin
      mul_done   <= 1'b1;
      mul_result <= sprod(mul_m, mul_q);
    end else if (cnt == 1) begin
      mul_done   <= 1'b1;
      mul_result <= sprod(mul_m, mul_q);
      cnt        <= 0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  task automatic drive();
    req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      req_m[i*W +: W] = m_a[i];
      req_q[i*W +: W] = q_a[i];
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic req(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
    vld[i] = 1'b1;
    m_a[i] = m;
    q_a[i] = q;
    drive();
  endtask

  // compare DUT against the model mid-cycle, then advance the model by one clock
  task automatic monitor();
    logic [NREQ-1:0] exp_rdy;
    logic rise;
    int win, idx;
    exp_rdy = '0;
    win = -1;
    if (phase == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (ref_last + k) % NREQ;
        if (win < 0 && vld[idx]) win = idx;
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
    end
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("busy", 64'(busy), 64'(phase != 0));
    check_eq("mul_start", 64'(mul_start), 64'(phase == 1));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(phase == 3));
    if (mul_start) start_cnt++;
    if (phase != 0) begin
      check_eq("mul_m", 64'(mul_m), 64'(cur_m));
      check_eq("mul_q", 64'(mul_q), 64'(cur_q));
    end
    if (phase == 3) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(cur_id));
      check_eq("rsp_data", rsp_data, cur_data);
      check_eq("rsp_err", 64'(rsp_err), 64'(cur_err));
    end
    rise = mul_done && !prev_done;
    prev_done = mul_done;
    case (phase)
      0: if (win >= 0) begin
        cur_id = win; cur_m = m_a[win]; cur_q = q_a[win];
        acc_vec = exp_rdy;
        grant_log.push_back(win);
        phase = 1;
      end
      1: begin w = 0; phase = 2; end
      2: begin
        if (rise) begin
          cur_data = sprod(cur_m, cur_q); cur_err = 1'b0; phase = 3;
        end else begin
          w++;
          if (w == TO_CYC) begin cur_data = '0; cur_err = 1'b1; phase = 3; end
        end
      end
      3: if (rsp_ready) begin
        rsp_log_id.push_back(cur_id);
        rsp_log_data.push_back(cur_data);
        rsp_log_err.push_back(cur_err);
        n_rsp++;
        ref_last = cur_id;
        phase = cur_err ? 4 : 0;
      end
      4: if (rise) phase = 0;
      default: phase = 0;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc_vec[i]) vld[i] = 1'b0;
    acc_vec = '0;
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(3) == 0) begin
          vld[i] = 1'b1; m_a[i] = rnd_op(); q_a[i] = rnd_op();
        end
      end
    end
    rsp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    vld = '0;
    drive();
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mul_start", 64'(mul_start), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_data", rsp_data, 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("rst_mul_m", 64'(mul_m), 64'd0);
    check_eq("rst_mul_q", 64'(mul_q), 64'd0);
    phase = 0; ref_last = NREQ - 1; prev_done = 1'b0; acc_vec = '0; w = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int c;
    c = 0;
    while (n_rsp < n && c < budget) begin cycle(); c++; end
    check_eq("wait_rsp", 64'(n_rsp >= n), 64'd1);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int c;
    c = 0;
    while (phase != p && c < budget) begin cycle(); c++; end
    check_eq("wait_phase", 64'(phase == p), 64'd1);
  endtask

  initial begin
    int g0, c;
    vld = '0; acc_vec = '0; rr_mode = 0; rand_mode = 1'b0; hang = 1'b0; rel_done = 1'b0;
    lat_lo = 1; lat_hi = 12; rsp_ready = 1'b1;
    n_rsp = 0; start_cnt = 0; phase = 0; ref_last = NREQ - 1; w = 0; cur_id = 0;
    cur_m = '0; cur_q = '0; cur_data = '0; cur_err = 1'b0; prev_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin m_a[i] = '0; q_a[i] = '0; end
    drive();
    #2;
    apply_reset();

    // single job from r0: 3 * -5
    start_cnt = 0;
    req(0, 32'd3, 32'hFFFF_FFFB);
    wait_rsp(1, 100);
    repeat (3) cycle();
    check_eq("t1_data", rsp_log_data[0], 64'hFFFF_FFFF_FFFF_FFF1);
    check_eq("t1_id", 64'(rsp_log_id[0]), 64'd0);
    check_eq("t1_starts", 64'(start_cnt), 64'd1);

    // all four at once after reset, then r0 and r2 again
    apply_reset();
    g0 = grant_log.size();
    for (int i = 0; i < NREQ; i++) req(i, W'(i + 1), 32'd10);
    wait_rsp(n_rsp + 4, 200);
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_order", 64'(grant_log[g0 + k]), 64'(k));
      check_eq("t2_prod", rsp_log_data[g0 + k], 64'(10 * (k + 1)));
    end
    g0 = grant_log.size();
    req(0, 32'd7, 32'd7);
    req(2, 32'd9, 32'hFFFF_FFFF);
    wait_rsp(n_rsp + 2, 200);
    check_eq("t2_rr0", 64'(grant_log[g0]), 64'd0);
    check_eq("t2_rr1", 64'(grant_log[g0 + 1]), 64'd2);

    // response back-pressure for 20 cycles with another requester waiting
    lat_lo = 3; lat_hi = 3;
    c = n_rsp;
    req(1, 32'h1234_5678, 32'hFEDC_BA98);
    req(3, 32'd100, 32'hFFFF_FF00);
    rr_mode = 2;
    wait_phase(3, 50);
    repeat (20) cycle();
    rr_mode = 0;
    wait_rsp(c + 2, 200);

    // hung multiplier: timeout, then no grants until the late done arrives
    hang = 1'b1;
    c = n_rsp;
    req(2, 32'd5, 32'd6);
    wait_rsp(c + 1, 100);
    check_eq("t4_err", 64'(rsp_log_err[c]), 64'd1);
    check_eq("t4_data", rsp_log_data[c], 64'd0);
    g0 = grant_log.size();
    req(1, 32'd11, 32'd12);
    repeat (10) cycle();
    check_eq("t4_no_grant", 64'(grant_log.size()), 64'(g0));
    rel_done = 1'b1;
    cycle();
    rel_done = 1'b0;
    hang = 1'b0;
    wait_rsp(c + 2, 100);
    check_eq("t4_resume_id", 64'(rsp_log_id[c + 1]), 64'd1);
    check_eq("t4_resume_data", rsp_log_data[c + 1], 64'd132);

    // reset while waiting on the multiplier
    lat_lo = 40; lat_hi = 40;
    req(3, 32'd2, 32'd2);
    wait_phase(2, 20);
    repeat (5) cycle();
    c = n_rsp;
    apply_reset();
    lat_lo = 1; lat_hi = 12;
    repeat (3) cycle();
    check_eq("t5_no_rsp", 64'(n_rsp), 64'(c));
    g0 = grant_log.size();
    req(1, 32'd4, 32'd4);
    req(0, 32'd8, 32'd8);
    wait_rsp(c + 2, 200);
    check_eq("t5_first", 64'(grant_log[g0]), 64'd0);
    check_eq("t5_second", 64'(grant_log[g0 + 1]), 64'd1);

    // extreme operands
    c = n_rsp;
    req(0, 32'h8000_0000, 32'h8000_0000);
    wait_rsp(c + 1, 100);
    check_eq("t6_minmin", rsp_log_data[c], 64'h4000_0000_0000_0000);
    req(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(c + 2, 100);
    check_eq("t6_maxneg1", rsp_log_data[c + 1], 64'hFFFF_FFFF_8000_0001);

    // random traffic with random back-pressure
    rand_mode = 1'b1;
    rr_mode = 1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    c = 0;
    while ((vld != '0 || phase != 0) && c < 3000) begin cycle(); c++; end
    check_eq("final_drain", 64'(vld == '0 && phase == 0), 64'd1);
    rr_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
